controlador_luz_multicanal: RTL

- N-channel lighting controller. Each channel is an independent 4-state auto/manual FSM with an integrated presence timeout.
- Generalises the single-channel light FSM in three ways: channel count is a parameter, buttons are edge-detected internally, and the auto-off timer is built in rather than supplied by a separate block.
- Sits between debounced panel buttons / presence sensors and the lamp drivers and indicator LEDs.

---
 rtl/controlador_luz_multicanal.sv | 106 ++++++++++
 1 files changed

// File: rtl/controlador_luz_multicanal.sv
// N-channel lighting controller: one auto/manual FSM per channel with internal
// button edge detection and a built-in presence timeout.
module controlador_luz_multicanal #(
    parameter int N_CANAIS  = 4,
    parameter int T_DESLIGA = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CANAIS-1:0]           modo,
    input  logic [N_CANAIS-1:0]           botao,
    input  logic [N_CANAIS-1:0]           presenca,
    input  logic                          desliga_tudo,
    output logic [N_CANAIS-1:0]           led,
    output logic [N_CANAIS-1:0]           saida,
    output logic [N_CANAIS-1:0]           contando,
    output logic [$clog2(N_CANAIS+1)-1:0] n_acesos
);
    localparam int CW = $clog2(T_DESLIGA);
    localparam int NW = $clog2(N_CANAIS + 1);

    typedef enum logic [1:0] {
        AUTO_OFF = 2'b00,
        AUTO_ON  = 2'b01,
        MAN_OFF  = 2'b10,
        MAN_ON   = 2'b11
    } state_t;

    logic [N_CANAIS-1:0] modo_prev_reg;
    logic [N_CANAIS-1:0] botao_prev_reg;
    logic [N_CANAIS-1:0] rise_modo;
    logic [N_CANAIS-1:0] rise_botao;

    // Loaded during reset too, so a button held through reset yields no edge.
    always_ff @(posedge clk) begin
        modo_prev_reg  <= modo;
        botao_prev_reg <= botao;
    end

    assign rise_modo  = modo  & ~modo_prev_reg;
    assign rise_botao = botao & ~botao_prev_reg;

    generate
        for (genvar gi = 0; gi < N_CANAIS; gi++) begin : g_canal
            state_t          state_reg, state_next;
            logic [CW-1:0]   cnt_reg, cnt_next;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= AUTO_OFF;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // The counter only runs in AUTO_ON; every other path leaves it at 0.
            always_comb begin
                state_next = state_reg;
                cnt_next   = '0;
                if (desliga_tudo) begin
                    state_next = MAN_OFF;
                end else if (rise_modo[gi]) begin
                    if (state_reg == AUTO_OFF || state_reg == AUTO_ON)
                        state_next = MAN_OFF;
                    else
                        state_next = AUTO_ON;
                end else begin
                    case (state_reg)
                        AUTO_OFF: begin
                            if (presenca[gi])
                                state_next = AUTO_ON;
                        end
                        AUTO_ON: begin
                            if (!presenca[gi]) begin
                                if (cnt_reg == CW'(T_DESLIGA - 1))
                                    state_next = AUTO_OFF;
                                else
                                    cnt_next = cnt_reg + CW'(1);
                            end
                        end
                        MAN_OFF: begin
                            if (rise_botao[gi])
                                state_next = MAN_ON;
                        end
                        MAN_ON: begin
                            if (rise_botao[gi])
                                state_next = MAN_OFF;
                        end
                        default: state_next = AUTO_OFF;
                    endcase
                end
            end

            assign led[gi]      = (state_reg == MAN_OFF) || (state_reg == MAN_ON);
            assign saida[gi]    = (state_reg == AUTO_ON) || (state_reg == MAN_ON);
            assign contando[gi] = (state_reg == AUTO_ON);
        end
    endgenerate

    always_comb begin
        n_acesos = '0;
        for (int i = 0; i < N_CANAIS; i++)
            n_acesos = n_acesos + NW'(saida[i]);
    end
endmodule
